// File: rtl/shinnosuke_mac_stream.sv
// shinnosuke_mac_stream: streaming multiply-accumulate (dot-product) engine.
//
// Accepts N_TERMS unsigned operand pairs over a valid/ready input stream. Each
// pair is multiplied in a registered product stage, the products are summed in
// an ACC_W-bit accumulator, and one frame sum is presented per frame on a
// valid/ready output stream.
//
// Build option:
//   SHINNOSUKE_MAC_SAT_EN  defined   -> accumulator saturates at 2^ACC_W-1
//                          undefined -> accumulator wraps modulo 2^ACC_W
//   out_ovf flags the overflow in both builds.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept a pair this cycle
//   in_a       operand A (IN_W bits, unsigned)
//   in_b       operand B (IN_W bits, unsigned)
//   out_valid  frame result valid
//   out_ready  sink accepts result
//   out_data   frame sum (ACC_W bits)
//   out_ovf    accumulator overflowed during this frame

module shinnosuke_mac_stream #(
    parameter int unsigned IN_W    = 4,
    parameter int unsigned N_TERMS = 8,
    parameter int unsigned ACC_W   = 2 * IN_W + $clog2(N_TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    // A one-term frame still needs a 1-bit counter to keep widths legal.
    localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int unsigned P_W   = 2 * IN_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StOut
    } state_e;

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [P_W-1:0]    p_q;
    logic              p_valid;
    logic [ACC_W-1:0]  acc;
    logic              ovf;

    logic              accept;
    logic              out_fire;
    logic [ACC_W-1:0]  p_ext;
    logic [ACC_W:0]    sum;
    logic              carry;
    logic [ACC_W-1:0]  acc_next;

    // in_ready is forced low while rst is asserted so nothing can slip in
    // during the reset cycle itself.
    assign in_ready  = (state == StRun) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == StOut);
    assign out_fire  = out_valid && out_ready;
    assign out_data  = acc;
    assign out_ovf   = ovf;

    // Size cast zero-extends or truncates the product to the accumulator width.
    assign p_ext = ACC_W'(p_q);
    assign sum   = {1'b0, acc} + {1'b0, p_ext};
    assign carry = sum[ACC_W];

`ifdef SHINNOSUKE_MAC_SAT_EN
    // Once clamped the accumulator is all ones, so any later add either carries
    // again or adds zero; both keep it at the ceiling.
    assign acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StRun;
            cnt     <= '0;
            p_q     <= '0;
            p_valid <= 1'b0;
            acc     <= '0;
            ovf     <= 1'b0;
        end else begin
            // Product stage
            p_valid <= accept;
            if (accept) begin
                p_q <= P_W'(in_a) * P_W'(in_b);
            end

            // Accumulate stage
            if (p_valid) begin
                acc <= acc_next;
                if (carry) begin
                    ovf <= 1'b1;
                end
            end

            // Frame control
            case (state)
                StRun: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= StDrain;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    // The last product accumulates during this cycle.
                    state <= StOut;
                end
                StOut: begin
                    if (out_fire) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        state <= StRun;
                    end
                end
                default: begin
                    state <= StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shinnosuke_mac_stream.sv
// Bench for shinnosuke_mac_stream. Two instances share the stimulus: the default
// build (ACC_W=11, never overflows at 8 terms of 4-bit operands) and ACC_W=10,
// which overflows on large frames. Expected sums come from plain arithmetic on
// the full-precision dot product.

module tb_shinnosuke_mac_stream;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;

    logic        in_ready, out_valid, out_ovf;
    logic [10:0] out_data;
    logic        in_ready10, out_valid10, out_ovf10;
    logic [9:0]  out_data10;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int fa [N];
    int fb [N];
    bit fbub [N];

    shinnosuke_mac_stream u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    shinnosuke_mac_stream #(.ACC_W(10)) u_dut10 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready10),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid10),
        .out_ready(out_ready),
        .out_data (out_data10),
        .out_ovf  (out_ovf10)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the frame result is the true dot product reduced to w bits.
    function automatic logic [31:0] model_data(input longint s, input int w);
        longint lim;
        lim = longint'(1) << w;
`ifdef SHINNOSUKE_MAC_SAT_EN
        return (s >= lim) ? 32'(lim - 1) : 32'(s);
`else
        return 32'(s % lim);
`endif
    endfunction

    function automatic logic [31:0] model_ovf(input longint s, input int w);
        return (s >= (longint'(1) << w)) ? 32'd1 : 32'd0;
    endfunction

    task automatic chk_result(input string tag, input longint s);
        chk({tag, "/out_valid"},   32'(out_valid),   32'd1);
        chk({tag, "/out_data"},    32'(out_data),    model_data(s, 11));
        chk({tag, "/out_ovf"},     32'(out_ovf),     model_ovf(s, 11));
        chk({tag, "/in_ready"},    32'(in_ready),    32'd0);
        chk({tag, "/out_valid10"}, 32'(out_valid10), 32'd1);
        chk({tag, "/out_data10"},  32'(out_data10),  model_data(s, 10));
        chk({tag, "/out_ovf10"},   32'(out_ovf10),   model_ovf(s, 10));
    endtask

    // Runs one frame from fa/fb/fbub. Entered and left at a falling edge.
    // ocyc is the cycle number of the first OUT cycle.
    task automatic do_frame(input string tag, input int stall, output int ocyc);
        longint s = 0;
        out_ready = (stall == 0);
        for (int i = 0; i < N; i++) begin
            if (fbub[i]) begin
                in_valid = 1'b0;
                in_a     = 4'($urandom);
                in_b     = 4'($urandom);
                @(posedge clk);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_a     = 4'(fa[i]);
            in_b     = 4'(fb[i]);
            s += longint'(fa[i] * fb[i]);
            chk({tag, "/accept_ready"}, 32'(in_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        // DRAIN cycle: junk stays offered and must be ignored until after OUT.
        in_a = 4'($urandom);
        in_b = 4'($urandom);
        chk({tag, "/drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "/drain_ready"}, 32'(in_ready),  32'd0);
        @(posedge clk);
        @(negedge clk);
        ocyc = cyc;
        for (int k = 0; k < stall; k++) begin
            chk_result({tag, "/stall"}, s);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk_result(tag, s);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "/post_valid"},   32'(out_valid),  32'd0);
        chk({tag, "/post_ready"},   32'(in_ready),   32'd1);
        chk({tag, "/post_ready10"}, 32'(in_ready10), 32'd1);
    endtask

    task automatic fill_const(input int a, input int b, input bit alt_bubbles);
        for (int i = 0; i < N; i++) begin
            fa[i]   = a;
            fb[i]   = b;
            fbub[i] = alt_bubbles && (i > 0);
        end
    endtask

    initial begin
        int c1, c2, c3;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset/in_ready",  32'(in_ready),  32'd0);
        chk("reset/out_valid", 32'(out_valid), 32'd0);
        chk("reset/out_data",  32'(out_data),  32'd0);
        chk("reset/out_ovf",   32'(out_ovf),   32'd0);
        rst = 1'b0;
        #1;
        chk("release/in_ready", 32'(in_ready), 32'd1);

        // Basic 8x(3,5) = 120
        fill_const(3, 5, 1'b0);
        do_frame("basic", 0, c1);

        // All-max operands with a bubble before every term after the first
        fill_const(15, 15, 1'b1);
        do_frame("max_bubble", 0, c1);

        // Backpressure: result held for 5 cycles
        fill_const(9, 11, 1'b0);
        do_frame("backpressure", 5, c1);

        // Mid-frame reset discards the partial sum and pending product
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 4'd7;
            in_b     = 4'd7;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst/in_ready_hi", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst/in_ready",  32'(in_ready),  32'd0);
        chk("midrst/out_valid", 32'(out_valid), 32'd0);
        chk("midrst/out_data",  32'(out_data),  32'd0);
        rst = 1'b0;
        #1;
        chk("midrst/release", 32'(in_ready), 32'd1);
        fill_const(1, 1, 1'b0);
        do_frame("after_rst", 0, c1);

        // Back-to-back frames with out_ready tied high: period N+2
        fill_const(2, 2, 1'b0);
        do_frame("b2b_a", 0, c1);
        fill_const(1, 4, 1'b0);
        do_frame("b2b_b", 0, c2);
        fill_const(3, 3, 1'b0);
        do_frame("b2b_c", 0, c3);
        chk("b2b/period_ab", 32'(c2 - c1), 32'(N + 2));
        chk("b2b/period_bc", 32'(c3 - c2), 32'(N + 2));

        // Randomized frames: operands, bubbles and backpressure
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < N; i++) begin
                fa[i]   = int'($urandom_range(0, 15));
                fb[i]   = int'($urandom_range(0, 15));
                fbub[i] = ($urandom_range(0, 3) == 0);
            end
            do_frame($sformatf("rand%0d", f), int'($urandom_range(0, 3)), c1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
